// File: rtl/serial_rx.sv
// serial_rx: start/N data LSB-first/even parity/stop receiver with valid/ready output and sticky overrun
module serial_rx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_in,
  input  logic         out_ready,
  output logic [N-1:0] p_out,
  output logic         out_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t         state;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bits;
  logic [N-1:0]   shreg;
  logic           perr;
  logic           armed;
  logic           half;
  logic           full;
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bits       <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      armed      <= 1'b0;
      p_out      <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      armed <= armed | s_in;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (armed && !s_in) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (half) begin
          cnt   <= '0;
          bits  <= '0;
          state <= s_in ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (full) begin
          cnt   <= '0;
          shreg <= {s_in, shreg[N-1:1]};
          bits  <= bits + 1'b1;
          if (bits == BW'(N - 1)) state <= PARITY;
        end else cnt <= cnt + 1'b1;
        PARITY: if (full) begin
          cnt   <= '0;
          perr  <= ^shreg ^ s_in;
          state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (full) begin
          cnt   <= '0;
          state <= IDLE;
          if (out_valid && !out_ready) overrun <= 1'b1;
          else begin
            p_out      <= shreg;
            parity_err <= perr;
            frame_err  <= !s_in;
            out_valid  <= 1'b1;
          end
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: cycle-accurate check of serial_rx against a frame-level reference model
module tb_serial_rx;
  localparam int N  = 8;
  localparam int C  = 4;
  localparam int FR = (N + 3) * C;
  localparam int DL = C / 2 + (N + 2) * C;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_in = 1'b1;
  logic         out_ready = 1'b1;
  logic [N-1:0] p_out;
  logic         out_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
  int           compared = 0;
  int           mismatched = 0;
  string        tag = "reset";
  bit           rand_rdy = 1'b0;
  int           rdy_at = -1;
  logic         ev = 1'b0;
  logic [N-1:0] ep = '0;
  logic         epe = 1'b0;
  logic         efe = 1'b0;
  logic         eov = 1'b0;
  serial_rx #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .out_ready(out_ready), .p_out(p_out),
    .out_valid(out_valid), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic tick(input bit dlv, input logic [N-1:0] d, input logic pe, input logic fe);
    @(posedge clk);
    #1;
    if (rst) begin
      ev = 1'b0; ep = '0; epe = 1'b0; efe = 1'b0; eov = 1'b0;
    end else if (dlv) begin
      if (ev && !out_ready) eov = 1'b1;
      else begin
        ev = 1'b1; ep = d; epe = pe; efe = fe;
      end
    end else if (ev && out_ready) ev = 1'b0;
    compared++;
    assert ({out_valid, p_out, parity_err, frame_err, overrun} === {ev, ep, epe, efe, eov}) else begin
      mismatched++;
      $error("FAIL %s: got v=%b p=%h pe=%b fe=%b ov=%b want v=%b p=%h pe=%b fe=%b ov=%b",
             tag, out_valid, p_out, parity_err, frame_err, overrun, ev, ep, epe, efe, eov);
    end
  endtask
  task automatic idle(input int n);
    s_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) out_ready = 1'($urandom % 2);
      tick(1'b0, '0, 1'b0, 1'b0);
    end
  endtask
  task automatic send(input logic [N-1:0] d, input logic pb, input logic sb);
    logic [N+2:0] fb;
    fb = {sb, pb, d, 1'b0};
    for (int j = 0; j < FR; j++) begin
      s_in = fb[j / C];
      if (rand_rdy) out_ready = 1'($urandom % 2);
      if (j == rdy_at) out_ready = 1'b1;
      tick(j == DL, d, ^d ^ pb, !sb);
    end
    s_in = 1'b1;
  endtask
  initial begin
    logic [N-1:0] d;
    logic         pb;
    logic         sb;
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(3);
    tag = "a5_basic";
    send(8'hA5, 1'b0, 1'b1);
    idle(2);
    tag = "07_parity";
    send(8'h07, 1'b0, 1'b1);
    tag = "3c_frame";
    send(8'h3C, 1'b0, 1'b0);
    idle(2);
    tag = "ready_on_completion";
    out_ready = 1'b0;
    send(8'h12, 1'b0, 1'b1);
    rdy_at = DL;
    send(8'h55, 1'b0, 1'b1);
    rdy_at = -1;
    idle(2);
    tag = "overrun";
    out_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    idle(2);
    out_ready = 1'b1;
    idle(3);
    tag = "false_start";
    s_in = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
    s_in = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b1);
    idle(2);
    tag = "reset_mid_frame";
    for (int j = 0; j < 22; j++) begin
      s_in = (j < C) ? 1'b0 : 1'b1;
      tick(1'b0, '0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    s_in = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    tag = "unarmed_low";
    for (int i = 0; i < 60; i++) tick(1'b0, '0, 1'b0, 1'b0);
    idle(3);
    tag = "after_rearm";
    send(8'hC3, 1'b0, 1'b1);
    idle(2);
    tag = "random";
    rand_rdy = 1'b1;
    for (int f = 0; f < 25; f++) begin
      d  = N'($urandom);
      pb = (^d) ^ ($urandom % 4 == 0);
      sb = ($urandom % 4 != 0);
      send(d, pb, sb);
      idle(int'($urandom % 3));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
